// File: rtl/axis_splitter_pkg.sv
// Shared definitions for the N-port AXI4-Stream splitter: register map,
// CTRL bit positions, stream FSM states and routing modes.
package axis_splitter_pkg;

    localparam logic [6:0] REG_CTRL     = 7'h00;
    localparam logic [6:0] REG_ROUTE    = 7'h04;
    localparam logic [6:0] REG_STATUS   = 7'h08;
    localparam logic [6:0] REG_DROP_CNT = 7'h0C;
    localparam logic [6:0] REG_PKT_BASE = 7'h40;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
    typedef enum logic {MODE_FIXED, MODE_RR} mode_t;

endpackage

// File: rtl/axis_splitter_ctrl_regs.sv
// AXI4-Lite slave for the splitter: CTRL/ROUTE storage, clear pulse and
// read-back of status and packet/drop counters.
module axis_splitter_ctrl_regs
    import axis_splitter_pkg::*;
#(
    parameter int PORT_COUNT = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 s_axi_ctrl_awvalid,
    output logic                                 s_axi_ctrl_awready,
    input  logic [6:0]                           s_axi_ctrl_awaddr,
    input  logic                                 s_axi_ctrl_wvalid,
    output logic                                 s_axi_ctrl_wready,
    input  logic [31:0]                          s_axi_ctrl_wdata,
    input  logic [3:0]                           s_axi_ctrl_wstrb,
    output logic                                 s_axi_ctrl_bvalid,
    input  logic                                 s_axi_ctrl_bready,
    output logic [1:0]                           s_axi_ctrl_bresp,
    input  logic                                 s_axi_ctrl_arvalid,
    output logic                                 s_axi_ctrl_arready,
    input  logic [6:0]                           s_axi_ctrl_araddr,
    output logic                                 s_axi_ctrl_rvalid,
    input  logic                                 s_axi_ctrl_rready,
    output logic [31:0]                          s_axi_ctrl_rdata,
    output logic [1:0]                           s_axi_ctrl_rresp,
    output mode_t                                mode,
    output logic [3:0]                           route,
    output logic                                 clear,
    input  logic [7:0]                           status,
    input  logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] pkt_cnt,
    input  logic [CNT_WIDTH-1:0]                 drop_cnt
);

    logic        wr_fire, rd_fire;
    logic [31:0] rd_val;
    logic        unused_wr;

    // Only one outstanding response per channel, so accept only while idle.
    assign wr_fire = s_axi_ctrl_awvalid && s_axi_ctrl_wvalid && !s_axi_ctrl_bvalid;
    assign rd_fire = s_axi_ctrl_arvalid && !s_axi_ctrl_rvalid;

    assign s_axi_ctrl_awready = wr_fire;
    assign s_axi_ctrl_wready  = wr_fire;
    assign s_axi_ctrl_arready = rd_fire;
    assign s_axi_ctrl_bresp   = 2'b00;
    assign s_axi_ctrl_rresp   = 2'b00;
    assign unused_wr          = ^{s_axi_ctrl_wstrb, s_axi_ctrl_wdata[31:4]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode              <= MODE_FIXED;
            route             <= '0;
            clear             <= 1'b0;
            s_axi_ctrl_bvalid <= 1'b0;
        end else begin
            clear <= 1'b0;
            if (wr_fire) begin
                s_axi_ctrl_bvalid <= 1'b1;
                case (s_axi_ctrl_awaddr)
                    REG_CTRL: begin
                        mode  <= s_axi_ctrl_wdata[CTRL_MODE_BIT] ? MODE_RR : MODE_FIXED;
                        clear <= s_axi_ctrl_wdata[CTRL_CLEAR_BIT];
                    end
                    REG_ROUTE: route <= s_axi_ctrl_wdata[3:0];
                    default: ;
                endcase
            end else if (s_axi_ctrl_bready) begin
                s_axi_ctrl_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (s_axi_ctrl_araddr)
            REG_CTRL:     rd_val[CTRL_MODE_BIT] = (mode == MODE_RR);
            REG_ROUTE:    rd_val[3:0] = route;
            REG_STATUS:   rd_val[7:0] = status;
            REG_DROP_CNT: rd_val = 32'(drop_cnt);
            default: begin
                for (int i = 0; i < PORT_COUNT; i++)
                    if (s_axi_ctrl_araddr == REG_PKT_BASE + 7'(4 * i))
                        rd_val = 32'(pkt_cnt[i]);
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_ctrl_rvalid <= 1'b0;
            s_axi_ctrl_rdata  <= '0;
        end else if (rd_fire) begin
            s_axi_ctrl_rvalid <= 1'b1;
            s_axi_ctrl_rdata  <= rd_val;
        end else if (s_axi_ctrl_rready) begin
            s_axi_ctrl_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_splitter_nport_axilite.sv
// N-way AXI4-Stream packet splitter: whole packets go to one master port
// (fixed ROUTE or round-robin) or are dropped; zero-latency pass-through.
module axis_splitter_nport_axilite
    import axis_splitter_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 48,
    parameter int PORT_COUNT  = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    input  logic [TDATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]              s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
    output logic [PORT_COUNT-1:0]                 m_axis_tvalid,
    input  logic [PORT_COUNT-1:0]                 m_axis_tready,
    output logic [PORT_COUNT-1:0]                 m_axis_tlast,
    output logic [TDATA_WIDTH*PORT_COUNT-1:0]     m_axis_tdata,
    output logic [TDATA_WIDTH/8*PORT_COUNT-1:0]   m_axis_tkeep,
    output logic [TUSER_WIDTH*PORT_COUNT-1:0]     m_axis_tuser,
    input  logic                                  s_axi_ctrl_awvalid,
    output logic                                  s_axi_ctrl_awready,
    input  logic [6:0]                            s_axi_ctrl_awaddr,
    input  logic                                  s_axi_ctrl_wvalid,
    output logic                                  s_axi_ctrl_wready,
    input  logic [31:0]                           s_axi_ctrl_wdata,
    input  logic [3:0]                            s_axi_ctrl_wstrb,
    output logic                                  s_axi_ctrl_bvalid,
    input  logic                                  s_axi_ctrl_bready,
    output logic [1:0]                            s_axi_ctrl_bresp,
    input  logic                                  s_axi_ctrl_arvalid,
    output logic                                  s_axi_ctrl_arready,
    input  logic [6:0]                            s_axi_ctrl_araddr,
    output logic                                  s_axi_ctrl_rvalid,
    input  logic                                  s_axi_ctrl_rready,
    output logic [31:0]                           s_axi_ctrl_rdata,
    output logic [1:0]                            s_axi_ctrl_rresp
);

    state_t                               state_q, state_d;
    mode_t                                mode;
    logic [3:0]                           route, dest_q, dest_live, rr_ptr_q;
    logic                                 clear, active_q, oob, hs, last_hs;
    logic [PORT_COUNT-1:0]                sel;
    logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] pkt_cnt;
    logic [CNT_WIDTH-1:0]                 drop_cnt;
    logic [7:0]                           status;

    // In IDLE the destination tracks the registers live; mid-packet it is frozen.
    assign dest_live = (state_q == IDLE) ? ((mode == MODE_RR) ? rr_ptr_q : route) : dest_q;
    assign oob       = (dest_live >= 4'(PORT_COUNT));

    always_comb begin
        sel = '0;
        for (int i = 0; i < PORT_COUNT; i++)
            sel[i] = (dest_live == 4'(i));
    end

    // active_q keeps the slave stalled until the first cycle out of reset.
    assign s_axis_tready = active_q && (oob || |(m_axis_tready & sel));
    assign m_axis_tvalid = (active_q && s_axis_tvalid) ? sel : '0;
    assign m_axis_tlast  = {PORT_COUNT{s_axis_tlast}};
    assign m_axis_tdata  = {PORT_COUNT{s_axis_tdata}};
    assign m_axis_tkeep  = {PORT_COUNT{s_axis_tkeep}};
    assign m_axis_tuser  = {PORT_COUNT{s_axis_tuser}};

    assign hs      = s_axis_tvalid && s_axis_tready;
    assign last_hs = hs && s_axis_tlast;
    assign status  = {dest_q, 2'b00, state_q == DROP, state_q != IDLE};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (hs && !s_axis_tlast) state_d = oob ? DROP : FWD;
            FWD, DROP: if (last_hs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            dest_q   <= '0;
            active_q <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            if (state_q == IDLE && hs)
                dest_q <= dest_live;
            if (last_hs && mode == MODE_RR)
                rr_ptr_q <= (rr_ptr_q == 4'(PORT_COUNT - 1)) ? 4'd0 : rr_ptr_q + 4'd1;
        end
    end

    // Clear has priority so a coincident packet end is lost, not counted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (clear) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (last_hs) begin
            for (int i = 0; i < PORT_COUNT; i++)
                if (sel[i]) pkt_cnt[i] <= pkt_cnt[i] + CNT_WIDTH'(1);
            if (oob) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    axis_splitter_ctrl_regs #(
        .PORT_COUNT (PORT_COUNT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_regs (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axi_ctrl_awvalid (s_axi_ctrl_awvalid),
        .s_axi_ctrl_awready (s_axi_ctrl_awready),
        .s_axi_ctrl_awaddr  (s_axi_ctrl_awaddr),
        .s_axi_ctrl_wvalid  (s_axi_ctrl_wvalid),
        .s_axi_ctrl_wready  (s_axi_ctrl_wready),
        .s_axi_ctrl_wdata   (s_axi_ctrl_wdata),
        .s_axi_ctrl_wstrb   (s_axi_ctrl_wstrb),
        .s_axi_ctrl_bvalid  (s_axi_ctrl_bvalid),
        .s_axi_ctrl_bready  (s_axi_ctrl_bready),
        .s_axi_ctrl_bresp   (s_axi_ctrl_bresp),
        .s_axi_ctrl_arvalid (s_axi_ctrl_arvalid),
        .s_axi_ctrl_arready (s_axi_ctrl_arready),
        .s_axi_ctrl_araddr  (s_axi_ctrl_araddr),
        .s_axi_ctrl_rvalid  (s_axi_ctrl_rvalid),
        .s_axi_ctrl_rready  (s_axi_ctrl_rready),
        .s_axi_ctrl_rdata   (s_axi_ctrl_rdata),
        .s_axi_ctrl_rresp   (s_axi_ctrl_rresp),
        .mode               (mode),
        .route              (route),
        .clear              (clear),
        .status             (status),
        .pkt_cnt            (pkt_cnt),
        .drop_cnt           (drop_cnt)
    );

endmodule

// File: tb/tb_axis_splitter_nport_axilite.sv
// Scoreboard bench for the N-port splitter: a packet-level model predicts the
// destination of every beat and the register contents; a monitor checks outputs.
module tb_axis_splitter_nport_axilite;
    import axis_splitter_pkg::*;

    localparam int TDW = 64;
    localparam int TUW = 8;
    localparam int PC  = 4;
    localparam int CW  = 32;

    typedef struct packed {
        logic [TDW-1:0]   d;
        logic [TDW/8-1:0] k;
        logic [TUW-1:0]   u;
        logic             l;
    } beat_t;

    logic aclk, aresetn;
    logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [TDW-1:0] s_axis_tdata;
    logic [TDW/8-1:0] s_axis_tkeep;
    logic [TUW-1:0] s_axis_tuser;
    logic [PC-1:0] m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [TDW*PC-1:0] m_axis_tdata;
    logic [TDW/8*PC-1:0] m_axis_tkeep;
    logic [TUW*PC-1:0] m_axis_tuser;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [6:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;

    axis_splitter_nport_axilite #(
        .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .PORT_COUNT(PC), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
        .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
        .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready),
        .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
        .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready),
        .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference model state
    int    route_m, mode_m, rr_m, drop_m;
    int    pkt_m[PC];
    int    cur_dest, beats_done, rdy_mode;
    bit    bubble_en, chk_en;
    beat_t exp_q[PC][$];
    int    n_chk, n_fail;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        route_m = 0; mode_m = 0; rr_m = 0; drop_m = 0;
        for (int i = 0; i < PC; i++) pkt_m[i] = 0;
    endtask

    task automatic model_clear();
        drop_m = 0;
        for (int i = 0; i < PC; i++) pkt_m[i] = 0;
    endtask

    // Downstream ready patterns
    initial begin
        bit tog;
        tog = 1'b0;
        m_axis_tready = '1;
        forever begin
            @(posedge aclk); #1;
            tog = ~tog;
            case (rdy_mode)
                0:       m_axis_tready = 4'($urandom);
                1:       m_axis_tready = '0;
                2:       m_axis_tready = {tog, 3'b111};
                default: m_axis_tready = '1;
            endcase
        end
    end

    // Monitor: routing mask, slave ready and beat content/order per port
    always @(negedge aclk) begin
        logic [PC-1:0] exp_mask;
        beat_t g, e;
        if (chk_en && aresetn) begin
            exp_mask = '0;
            if (s_axis_tvalid && cur_dest < PC) exp_mask[cur_dest] = 1'b1;
            check("tvalid_mask", m_axis_tvalid, exp_mask);
            if (s_axis_tvalid)
                check("s_tready", s_axis_tready, (cur_dest >= PC) ? 1'b1 : m_axis_tready[cur_dest]);
            for (int p = 0; p < PC; p++) begin
                if (m_axis_tvalid[p] && m_axis_tready[p]) begin
                    g.d = m_axis_tdata[p*TDW +: TDW];
                    g.k = m_axis_tkeep[p*(TDW/8) +: TDW/8];
                    g.u = m_axis_tuser[p*TUW +: TUW];
                    g.l = m_axis_tlast[p];
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("unexpected_beat_port%0d", p), g, '0);
                    end else begin
                        e = exp_q[p].pop_front();
                        check($sformatf("beat_port%0d", p), g, e);
                    end
                end
            end
        end
    end

    task automatic send_pkt(input int len, input int abort_after = 0);
        int d, t;
        bit hs;
        beat_t b;
        d = (mode_m != 0) ? rr_m : route_m;
        cur_dest = d;
        for (int i = 0; i < len; i++) begin
            if (abort_after != 0 && i == abort_after) begin
                s_axis_tvalid = 1'b0;
                return;
            end
            if (bubble_en && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
            b.d = {$urandom, $urandom};
            b.k = 8'($urandom);
            b.u = 8'($urandom);
            b.l = (i == len - 1);
            if (d < PC) exp_q[d].push_back(b);
            s_axis_tdata = b.d; s_axis_tkeep = b.k; s_axis_tuser = b.u; s_axis_tlast = b.l;
            s_axis_tvalid = 1'b1;
            hs = 1'b0; t = 0;
            while (!hs && t < 200) begin
                @(negedge aclk); hs = s_axis_tready;
                @(posedge aclk); #1; t++;
            end
            check("beat_handshake", hs, 1'b1);
            if (!hs) begin
                s_axis_tvalid = 1'b0;
                return;
            end
            beats_done++;
        end
        s_axis_tvalid = 1'b0;
        if (d < PC) pkt_m[d]++; else drop_m++;
        if (mode_m != 0) rr_m = (rr_m + 1) % PC;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] dat);
        int t; bit ok;
        awaddr = a; wdata = dat; wstrb = '1; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0; t = 0;
        while (!ok && t < 100) begin
            @(negedge aclk); ok = awready && wready;
            @(posedge aclk); #1; t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; ok = 1'b0; t = 0;
        while (!ok && t < 100) begin
            @(negedge aclk); ok = bvalid;
            if (ok) check("bresp", bresp, 2'b00);
            @(posedge aclk); #1; t++;
        end
        bready = 1'b0;
        check("write_response", ok, 1'b1);
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] dat);
        int t; bit ok;
        araddr = a; arvalid = 1'b1; ok = 1'b0; t = 0; dat = 'x;
        while (!ok && t < 100) begin
            @(negedge aclk); ok = arready;
            @(posedge aclk); #1; t++;
        end
        arvalid = 1'b0; rready = 1'b1; ok = 1'b0; t = 0;
        while (!ok && t < 100) begin
            @(negedge aclk); ok = rvalid;
            if (ok) begin
                dat = rdata;
                check("rresp", rresp, 2'b00);
            end
            @(posedge aclk); #1; t++;
        end
        rready = 1'b0;
        check("read_response", ok, 1'b1);
    endtask

    task automatic check_reg(input string name, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        check(name, v, exp);
    endtask

    task automatic check_counters();
        for (int i = 0; i < PC; i++)
            check_reg($sformatf("pkt_cnt%0d", i), REG_PKT_BASE + 7'(4 * i), 32'(pkt_m[i]));
        check_reg("drop_cnt", REG_DROP_CNT, 32'(drop_m));
    endtask

    initial begin
        int t;
        n_chk = 0; n_fail = 0; chk_en = 1'b0; bubble_en = 1'b0; rdy_mode = 3;
        cur_dest = 0; beats_done = 0;
        s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        model_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_tvalid", m_axis_tvalid, '0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_axil_ready", {awready, wready, arready}, 3'b000);
        check("rst_axil_valid", {bvalid, rvalid}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk); #1;
        chk_en = 1'b1;
        check_reg("rst_status", REG_STATUS, 32'h0);
        check_counters();

        // Fixed route to port 2
        rdy_mode = 0; bubble_en = 1'b1;
        axi_write(REG_ROUTE, 32'd2); route_m = 2;
        check_reg("route_rb", REG_ROUTE, 32'd2);
        send_pkt(3);
        check_counters();

        // ROUTE change mid-packet only affects the next packet
        axi_write(REG_ROUTE, 32'd0); route_m = 0;
        beats_done = 0;
        fork
            send_pkt(4);
            begin
                t = 0;
                while (beats_done < 1 && t < 500) begin @(posedge aclk); #1; t++; end
                axi_write(REG_ROUTE, 32'd1); route_m = 1;
            end
        join
        send_pkt(2);
        check_counters();

        // Round-robin over six single-beat packets
        axi_write(REG_CTRL, 32'h2); mode_m = 0; model_clear();
        axi_write(REG_CTRL, 32'h1); mode_m = 1;
        check_reg("ctrl_rb", REG_CTRL, 32'h1);
        repeat (6) send_pkt(1);
        check_counters();

        // Out-of-range route drops the packet while downstream stalls
        axi_write(REG_CTRL, 32'h0); mode_m = 0;
        axi_write(REG_ROUTE, 32'd7); route_m = 7;
        rdy_mode = 1;
        send_pkt(5);
        check_counters();

        // Port 3 ready toggling; slave ready must follow it
        axi_write(REG_ROUTE, 32'd3); route_m = 3;
        rdy_mode = 2; bubble_en = 1'b0;
        send_pkt(8);
        check("port3_drained", exp_q[3].size(), 0);

        // Random mix of modes, routes and lengths
        rdy_mode = 0; bubble_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                mode_m = int'($urandom_range(0, 1));
                axi_write(REG_CTRL, 32'(mode_m));
            end
            if ($urandom_range(0, 1) == 0) begin
                route_m = int'($urandom_range(0, 5));
                axi_write(REG_ROUTE, 32'(route_m));
            end
            send_pkt(int'($urandom_range(1, 6)));
        end
        check_counters();

        // Clear coinciding with a packet end
        rdy_mode = 3; bubble_en = 1'b0;
        fork
            send_pkt(1);
            axi_write(REG_CTRL, 32'(mode_m) | 32'h2);
        join
        model_clear();
        check_counters();
        check_reg("ctrl_clear_reads0", REG_CTRL, 32'(mode_m));

        // Reset in the middle of a packet
        axi_write(REG_CTRL, 32'h1); mode_m = 1;
        send_pkt(1);
        send_pkt(4, 2);
        check_reg("status_mid_pkt", REG_STATUS, 32'((cur_dest << 4) | 1));
        aresetn = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
        @(negedge aclk);
        check("midrst_m_tvalid", m_axis_tvalid, '0);
        check("midrst_s_tready", s_axis_tready, 1'b0);
        s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        model_reset();
        for (int p = 0; p < PC; p++) begin
            check($sformatf("queue_empty%0d", p), exp_q[p].size(), 0);
            exp_q[p].delete();
        end
        repeat (2) @(posedge aclk); #1;
        check_reg("status_after_rst", REG_STATUS, 32'h0);
        axi_write(REG_CTRL, 32'h1); mode_m = 1;
        send_pkt(2);
        check_counters();

        repeat (4) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
